sn76489_write_sched: RTL and testbench

//  Shares the SN76489 CPU write port (ce_n/we_n/d/ready) between NUM_REQ requesters (stimulus, sequencer, ...).

---
 rtl/sn76489_ctrl_pkg.sv | 46 ++++
 rtl/sn76489_rr_arbiter.sv | 47 ++++
 rtl/sn76489_write_sched.sv | 158 +++++++++++++++
 tb/tb_sn76489_write_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sn76489_ctrl_pkg.sv
// Shared constants, payload type and byte-formatting helpers for the SN76489 write scheduler.
package sn76489_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [2:0] REG_TONE1_FREQ  = 3'd0;
    localparam logic [2:0] REG_TONE1_ATTEN = 3'd1;
    localparam logic [2:0] REG_TONE2_FREQ  = 3'd2;
    localparam logic [2:0] REG_TONE2_ATTEN = 3'd3;
    localparam logic [2:0] REG_TONE3_FREQ  = 3'd4;
    localparam logic [2:0] REG_TONE3_ATTEN = 3'd5;
    localparam logic [2:0] REG_NOISE_CTRL  = 3'd6;
    localparam logic [2:0] REG_NOISE_ATTEN = 3'd7;

    typedef struct packed {
        logic [2:0] rsel;
        logic [9:0] val;
    } wr_req_t;

    function automatic logic is_freq(input logic [2:0] rsel);
        logic f;
        f = 1'b0;
        case (rsel)
            REG_TONE1_FREQ, REG_TONE2_FREQ, REG_TONE3_FREQ: f = 1'b1;
            REG_TONE1_ATTEN, REG_TONE2_ATTEN, REG_TONE3_ATTEN,
            REG_NOISE_CTRL, REG_NOISE_ATTEN: f = 1'b0;
            default: f = 1'b0;
        endcase
        return f;
    endfunction

    // Noise control carries only a 3-bit mode; bit 3 of the nibble is forced low.
    function automatic logic [7:0] latch_byte(input logic [2:0] rsel, input logic [9:0] val);
        if (rsel == REG_NOISE_CTRL)
            return {1'b1, rsel, 1'b0, val[2:0]};
        return {1'b1, rsel, val[3:0]};
    endfunction

    function automatic logic [7:0] data_byte(input logic [9:0] val);
        return {2'b00, val[9:4]};
    endfunction

endpackage

// File: rtl/sn76489_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting at a registered priority pointer.
module sn76489_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt_c
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_c = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!found && req[idx[PTR_W-1:0]]) begin
                found                  = 1'b1;
                gnt_c[idx[PTR_W-1:0]]  = 1'b1;
                ptr_d                  = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
        if (!en) begin
            gnt_c = '0;
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sn76489_write_sched.sv
// Shares the SN76489 CPU write port between requesters: arbitrates, formats latch/data bytes
// and runs the ce_n/we_n/ready handshake one byte at a time with a ready timeout.
module sn76489_write_sched
    import sn76489_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ARM_CYCLES     = 2,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [3*NUM_REQ-1:0]  reg_i,
    input  logic [10*NUM_REQ-1:0] val_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic                  ce_n_o,
    output logic                  we_n_o,
    output logic [7:0]            d_o,
    input  logic                  ready_i
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;

    logic [1:0]         state_q, state_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [9:0]         val_q, val_d;
    logic               second_q, second_d;
    logic               abort_q, abort_d;
    logic [7:0]         byte_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic               done_d;
    logic               timeout_d;
    logic               strobe_n_d;
    logic [NUM_REQ-1:0] arb_gnt_c;
    logic               arb_en_c;
    wr_req_t            pick_c;

    assign arb_en_c = (state_q == ST_IDLE);

    sn76489_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .req    (req_i),
        .en     (arb_en_c),
        .gnt_c  (arb_gnt_c)
    );

    // Payload of the requester the arbiter picked this cycle.
    always_comb begin
        pick_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt_c[k])
                pick_c = {reg_i[3*k +: 3], val_i[10*k +: 10]};
        end
    end

    // Next-state and next-output logic; the timeout counter runs from ARM entry until ready.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        val_d     = val_q;
        second_d  = second_q;
        abort_d   = abort_q;
        byte_d    = d_o;
        gnt_d     = '0;
        done_d    = 1'b0;
        timeout_d = timeout_o;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    gnt_d    = arb_gnt_c;
                    val_d    = pick_c.val;
                    byte_d   = latch_byte(pick_c.rsel, pick_c.val);
                    second_d = is_freq(pick_c.rsel);
                    abort_d  = 1'b0;
                    to_cnt_d = '0;
                    state_d  = ST_ARM;
                end
            end
            ST_ARM: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (to_cnt_q >= TO_W'(ARM_CYCLES - 1))
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (ready_i) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else if (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    second_d  = 1'b0;
                    abort_d   = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q >= GAP_W'(GAP_CYCLES - 1)) begin
                    if (second_q) begin
                        byte_d   = data_byte(val_q);
                        second_d = 1'b0;
                        to_cnt_d = '0;
                        state_d  = ST_ARM;
                    end else begin
                        done_d  = !abort_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        strobe_n_d = !((state_d == ST_ARM) || (state_d == ST_WAIT));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            val_q     <= '0;
            second_q  <= 1'b0;
            abort_q   <= 1'b0;
            d_o       <= 8'h00;
            gnt_o     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            ce_n_o    <= 1'b1;
            we_n_o    <= 1'b1;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            val_q     <= val_d;
            second_q  <= second_d;
            abort_q   <= abort_d;
            d_o       <= byte_d;
            gnt_o     <= gnt_d;
            busy_o    <= (state_d != ST_IDLE);
            done_o    <= done_d;
            timeout_o <= timeout_d;
            ce_n_o    <= strobe_n_d;
            we_n_o    <= strobe_n_d;
        end
    end

endmodule

// File: tb/tb_sn76489_write_sched.sv
// Randomized self-checking bench for sn76489_write_sched against an arithmetic byte/arbitration model.
module tb_sn76489_write_sched;

    localparam int NUM_REQ = 4;
    localparam int ARM     = 2;
    localparam int GAP     = 1;
    localparam int TMO     = 256;

    logic                  clock_i = 1'b0;
    logic                  reset_i;
    logic [NUM_REQ-1:0]    req_i;
    logic [3*NUM_REQ-1:0]  reg_i;
    logic [10*NUM_REQ-1:0] val_i;
    logic [NUM_REQ-1:0]    gnt_o;
    logic                  busy_o, done_o, timeout_o, ce_n_o, we_n_o;
    logic [7:0]            d_o;
    logic                  ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    // chip model: ready rises rdy_delay cycles after ce_n falls
    bit ready_en  = 1'b1;
    int rdy_delay = 0;
    int low_len   = 0;
    assign ready_i = ready_en && (low_len >= rdy_delay);

    sn76489_write_sched #(
        .NUM_REQ(NUM_REQ), .ARM_CYCLES(ARM), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i), .reg_i(reg_i), .val_i(val_i),
        .gnt_o(gnt_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .ce_n_o(ce_n_o), .we_n_o(we_n_o), .d_o(d_o), .ready_i(ready_i)
    );

    always #5 clock_i = ~clock_i;

    // bus monitor
    int obs[$];
    int lows[$];
    int gnt_idx[$];
    int exp_q[$];
    int done_cnt = 0, done_cyc = 0, gnt_cyc = 0, stab_err = 0, onehot_err = 0, cyc = 0;
    logic prev_ce_n = 1'b1;
    logic [7:0] cur_d = 8'h00;

    always @(negedge clock_i) begin
        cyc++;
        if (!ce_n_o) begin
            if (prev_ce_n) begin
                obs.push_back(int'(d_o));
                cur_d   = d_o;
                low_len = 0;
            end
            low_len++;
            if (d_o !== cur_d) stab_err++;
        end else begin
            if (!prev_ce_n) lows.push_back(low_len);
            low_len = 0;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (gnt_o != '0) begin
            if (!$onehot(gnt_o)) onehot_err++;
            for (int i = 0; i < NUM_REQ; i++) if (gnt_o[i]) gnt_idx.push_back(i);
            gnt_cyc = cyc;
        end
        prev_ce_n = ce_n_o;
    end

    // reference model
    function automatic int exp_latch(int rsel, int val);
        return 128 + rsel * 16 + ((rsel == 6) ? (val % 8) : (val % 16));
    endfunction

    function automatic bit two_bytes(int rsel);
        return (rsel == 0) || (rsel == 2) || (rsel == 4);
    endfunction

    task automatic add_exp(input int rsel, input int val);
        exp_q.push_back(exp_latch(rsel, val));
        if (two_bytes(rsel)) exp_q.push_back((val / 16) % 64);
    endtask

    function automatic int rr_pick(int ptr, int mask);
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = (ptr + i) % NUM_REQ;
            if (mask[j]) return j;
        end
        return -1;
    endfunction

    task automatic clear_mon();
        @(negedge clock_i);
        #1;
        obs.delete(); lows.delete(); gnt_idx.delete(); exp_q.delete();
        done_cnt = 0; stab_err = 0; onehot_err = 0;
    endtask

    task automatic do_write(input int k, input int rsel, input int val);
        bit got;
        @(negedge clock_i);
        reg_i[3*k +: 3]   = 3'(rsel);
        val_i[10*k +: 10] = 10'(val);
        req_i[k]          = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock_i);
            if (gnt_o != '0) got = 1'b1;
        end
        n_checks++;
        if (!got || gnt_o !== NUM_REQ'(1 << k)) begin
            n_fail++;
            $display("FAIL grant k=%0d: gnt_o=%b got=%0d, expected %b", k, gnt_o, got, NUM_REQ'(1 << k));
        end
        req_i[k] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < TMO + 50 && !got; c++) begin
            @(negedge clock_i);
            if (!busy_o) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL busy_release k=%0d: busy_o still %b after bound", k, busy_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_i = '0; reg_i = '0; val_i = '0; ready_en = 1'b1; rdy_delay = 0;
        repeat (3) @(negedge clock_i);
        n_checks++; if (ce_n_o !== 1'b1)   begin n_fail++; $display("FAIL reset_ce_n: got %b want 1", ce_n_o); end
        n_checks++; if (we_n_o !== 1'b1)   begin n_fail++; $display("FAIL reset_we_n: got %b want 1", we_n_o); end
        n_checks++; if (d_o !== 8'h00)     begin n_fail++; $display("FAIL reset_d: got %h want 00", d_o); end
        n_checks++; if (gnt_o !== '0)      begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt_o); end
        n_checks++; if (busy_o !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
        reset_i = 1'b0;
        @(negedge clock_i);
    endtask

    task automatic test_freq_write();
        int mn;
        clear_mon();
        add_exp(0, 'h2A5);
        do_write(0, 0, 'h2A5);
        repeat (3) @(negedge clock_i);
        #1;
        n_checks++;
        if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL freq_nbytes: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            int g;
            g = (i < obs.size()) ? obs[i] : -1;
            n_checks++;
            if (g != exp_q[i]) begin n_fail++; $display("FAIL freq_byte%0d: got %h want %h", i, g, exp_q[i]); end
        end
        mn = 1000;
        foreach (lows[i]) if (lows[i] < mn) mn = lows[i];
        n_checks++; if (mn < ARM + 1) begin n_fail++; $display("FAIL freq_ce_low: min %0d want >=%0d", mn, ARM + 1); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL freq_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_atten();
        clear_mon();
        do_write(1, 1, 'h3F7);
        @(negedge clock_i);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL atten_busy_after_done: got %b want 0", busy_o); end
        repeat (2) @(negedge clock_i);
        #1;
        n_checks++; if (obs.size() != 1) begin n_fail++; $display("FAIL atten_nbytes: got %0d want 1", obs.size()); end
        n_checks++; if (obs.size() < 1 || obs[0] != exp_latch(1, 'h3F7)) begin n_fail++; $display("FAIL atten_byte: got %0d want %h", (obs.size() > 0) ? obs[0] : -1, exp_latch(1, 'h3F7)); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL atten_done: got %0d want 1", done_cnt); end
        n_checks++; if (done_cyc - gnt_cyc != ARM + 1 + GAP) begin n_fail++; $display("FAIL atten_latency: got %0d want %0d", done_cyc - gnt_cyc, ARM + 1 + GAP); end
    endtask

    task automatic test_noise();
        clear_mon();
        do_write(2, 6, 5);
        repeat (3) @(negedge clock_i);
        #1;
        n_checks++; if (obs.size() != 1 || obs[0] != exp_latch(6, 5)) begin n_fail++; $display("FAIL noise_byte: got n=%0d b=%0d want %h", obs.size(), (obs.size() > 0) ? obs[0] : -1, exp_latch(6, 5)); end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL noise_d_stable: %0d changes while ce_n low", stab_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL noise_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_round_robin();
        int rs[NUM_REQ];
        int vv[NUM_REQ];
        int ord[$];
        int ptr, j, ng;
        bit got;
        reset_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b0;
        clear_mon();
        for (int i = 0; i < NUM_REQ; i++) begin
            rs[i] = $urandom_range(0, 7);
            vv[i] = $urandom_range(0, 1023);
            reg_i[3*i +: 3]   = 3'(rs[i]);
            val_i[10*i +: 10] = 10'(vv[i]);
        end
        ptr = 0;
        for (int i = 0; i < 6; i++) begin
            j = rr_pick(ptr, (i < 4) ? 15 : 10);
            ord.push_back(j);
            add_exp(rs[j], vv[j]);
            ptr = (j + 1) % NUM_REQ;
        end
        req_i = '1;
        ng = 0;
        for (int c = 0; c < 300 && ng < 6; c++) begin
            @(negedge clock_i);
            if (gnt_o != '0) begin
                ng++;
                if (ng == 4) req_i = 4'b1010;
                if (ng == 6) req_i = '0;
            end
        end
        req_i = '0;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clock_i);
            if (!busy_o) got = 1'b1;
        end
        repeat (3) @(negedge clock_i);
        #1;
        n_checks++; if (!got || ng != 6) begin n_fail++; $display("FAIL rr_progress: grants %0d idle %0d want 6 grants", ng, got); end
        n_checks++; if (gnt_idx.size() != ord.size()) begin n_fail++; $display("FAIL rr_ngrants: got %0d want %0d", gnt_idx.size(), ord.size()); end
        for (int i = 0; i < ord.size(); i++) begin
            int g;
            g = (i < gnt_idx.size()) ? gnt_idx[i] : -1;
            n_checks++;
            if (g != ord[i]) begin n_fail++; $display("FAIL rr_order%0d: got %0d want %0d", i, g, ord[i]); end
        end
        n_checks++; if (obs != exp_q) begin n_fail++; $display("FAIL rr_bytes: got %p want %p", obs, exp_q); end
        n_checks++; if (done_cnt != 6) begin n_fail++; $display("FAIL rr_done: got %0d want 6", done_cnt); end
        n_checks++; if (onehot_err != 0) begin n_fail++; $display("FAIL rr_onehot: %0d non-one-hot grants", onehot_err); end
    endtask

    task automatic test_timeout();
        int v;
        v = $urandom_range(0, 1023);
        clear_mon();
        ready_en = 1'b0;
        do_write(0, 4, v);
        repeat (3) @(negedge clock_i);
        #1;
        n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", timeout_o); end
        n_checks++; if (ce_n_o !== 1'b1) begin n_fail++; $display("FAIL to_ce_n: got %b want 1", ce_n_o); end
        n_checks++; if (obs.size() != 1 || obs[0] != exp_latch(4, v)) begin n_fail++; $display("FAIL to_bytes: got n=%0d want only latch %h", obs.size(), exp_latch(4, v)); end
        n_checks++; if (lows.size() < 1 || lows[0] != TMO) begin n_fail++; $display("FAIL to_duration: got %0d want %0d", (lows.size() > 0) ? lows[0] : -1, TMO); end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL to_no_done: got %0d want 0", done_cnt); end
        ready_en = 1'b1;
        rdy_delay = 1;
        clear_mon();
        v = $urandom_range(0, 1023);
        do_write(3, 5, v);
        repeat (3) @(negedge clock_i);
        #1;
        n_checks++; if (done_cnt != 1 || obs.size() != 1 || obs[0] != exp_latch(5, v)) begin n_fail++; $display("FAIL to_recover: done %0d nbytes %0d want 1/1", done_cnt, obs.size()); end
        n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", timeout_o); end
    endtask

    task automatic test_reset_mid();
        bit got;
        clear_mon();
        rdy_delay = 30;
        @(negedge clock_i);
        reg_i[3*2 +: 3]   = 3'd0;
        val_i[10*2 +: 10] = 10'($urandom_range(0, 1023));
        req_i[2]          = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock_i);
            if (gnt_o != '0) got = 1'b1;
        end
        req_i[2] = 1'b0;
        repeat (ARM + 2) @(negedge clock_i);
        n_checks++; if (!got || ce_n_o !== 1'b0) begin n_fail++; $display("FAIL rm_in_wait: got gnt %0d ce_n %b want 1/0", got, ce_n_o); end
        reset_i = 1'b1;
        @(negedge clock_i);
        n_checks++;
        if (ce_n_o !== 1'b1 || we_n_o !== 1'b1 || d_o !== 8'h00 || gnt_o !== '0 ||
            busy_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_outputs: ce_n %b we_n %b d %h gnt %b busy %b done %b to %b want 1 1 00 0 0 0 0",
                     ce_n_o, we_n_o, d_o, gnt_o, busy_o, done_o, timeout_o);
        end
        reset_i = 1'b0;
        rdy_delay = 0;
        repeat (20) @(negedge clock_i);
        #1;
        n_checks++; if (obs.size() != 1) begin n_fail++; $display("FAIL rm_no_second: got %0d bytes want 1", obs.size()); end
        n_checks++; if (done_cnt != 0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: done %0d busy %b want 0/0", done_cnt, busy_o); end
    endtask

    task automatic test_random();
        int mn;
        clear_mon();
        for (int t = 0; t < 12; t++) begin
            int k, rsel, v;
            k    = $urandom_range(0, NUM_REQ - 1);
            rsel = $urandom_range(0, 7);
            v    = $urandom_range(0, 1023);
            rdy_delay = $urandom_range(0, 5);
            add_exp(rsel, v);
            do_write(k, rsel, v);
        end
        repeat (3) @(negedge clock_i);
        #1;
        n_checks++; if (obs != exp_q) begin n_fail++; $display("FAIL rand_bytes: got %p want %p", obs, exp_q); end
        n_checks++; if (done_cnt != 12) begin n_fail++; $display("FAIL rand_done: got %0d want 12", done_cnt); end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL rand_d_stable: %0d changes while ce_n low", stab_err); end
        mn = 1000;
        foreach (lows[i]) if (lows[i] < mn) mn = lows[i];
        n_checks++; if (mn < ARM + 1) begin n_fail++; $display("FAIL rand_ce_low: min %0d want >=%0d", mn, ARM + 1); end
    endtask

    initial begin
        test_reset();
        test_freq_write();
        test_atten();
        test_noise();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
